// File: rtl/nn_param_loader.sv
// nn_param_loader
//   Streaming parameter loader for a two-layer neural network datapath.
//   Accepts one WIDTH-bit word per valid/ready handshake, in the fixed frame
//   order inputs, w1 (h outer, i inner), w2 (o outer, h inner), b1, b2.
//   Each word lands in a register bank that drives the parallel parameter
//   buses. Frame length errors (too short or too long) are flagged.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 opens a new frame (honoured only in IDLE)
//   s_valid/s_ready       stream handshake, s_data word, s_last end marker
//   inputs_flat .. b2_flat parameter buses, element k at [k*WIDTH +: WIDTH]
//   params_valid          buses hold a complete, error-free frame
//   load_done             one-cycle pulse on correct frame completion
//   frame_err             sticky: last frame had a length error
module nn_param_loader #(
  parameter int INPUT_SIZE  = 10,
  parameter int HIDDEN_SIZE = 10,
  parameter int OUTPUT_SIZE = 5,
  parameter int WIDTH       = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  input  logic [WIDTH-1:0]                         s_data,
  input  logic                                     s_last,
  output logic [INPUT_SIZE*WIDTH-1:0]              inputs_flat,
  output logic [HIDDEN_SIZE*INPUT_SIZE*WIDTH-1:0]  w1_flat,
  output logic [OUTPUT_SIZE*HIDDEN_SIZE*WIDTH-1:0] w2_flat,
  output logic [HIDDEN_SIZE*WIDTH-1:0]             b1_flat,
  output logic [OUTPUT_SIZE*WIDTH-1:0]             b2_flat,
  output logic                                     params_valid,
  output logic                                     load_done,
  output logic                                     frame_err
);

  localparam int TOTAL  = INPUT_SIZE + HIDDEN_SIZE*INPUT_SIZE +
                          OUTPUT_SIZE*HIDDEN_SIZE + HIDDEN_SIZE + OUTPUT_SIZE;
  localparam int CNT_W  = $clog2(TOTAL+1);
  localparam int OFF_W1 = INPUT_SIZE;
  localparam int OFF_W2 = OFF_W1 + HIDDEN_SIZE*INPUT_SIZE;
  localparam int OFF_B1 = OFF_W2 + OUTPUT_SIZE*HIDDEN_SIZE;
  localparam int OFF_B2 = OFF_B1 + HIDDEN_SIZE;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             pv_d, ld_d, fe_d;
  logic             we;
  logic [WIDTH-1:0] bank [TOTAL];

  // s_ready is a pure function of the state register, so it is Moore and
  // changes only on the clock edge.
  assign s_ready = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      params_valid <= 1'b0;
      load_done    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      params_valid <= pv_d;
      load_done    <= ld_d;
      frame_err    <= fe_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pv_d    = params_valid;
    ld_d    = 1'b0;
    fe_d    = frame_err;
    we      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          pv_d    = 1'b0;
          fe_d    = 1'b0;
        end
      end
      LOAD: begin
        if (s_valid) begin
          we    = 1'b1;
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_W'(TOTAL-1)) begin
            if (s_last) begin
              state_d = IDLE;
              pv_d    = 1'b1;
              ld_d    = 1'b1;
            end else begin
              state_d = DRAIN;
              fe_d    = 1'b1;
            end
          end else if (s_last) begin
            state_d = IDLE;
            fe_d    = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (s_valid && s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // cnt never exceeds TOTAL-1 while in LOAD, so the write index is in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < TOTAL; k++) bank[k] <= '0;
    end else if (we) begin
      bank[cnt] <= s_data;
    end
  end

  always_comb begin
    inputs_flat = '0;
    w1_flat     = '0;
    w2_flat     = '0;
    b1_flat     = '0;
    b2_flat     = '0;
    for (int unsigned k = 0; k < INPUT_SIZE; k++)
      inputs_flat[k*WIDTH +: WIDTH] = bank[k];
    for (int unsigned k = 0; k < HIDDEN_SIZE*INPUT_SIZE; k++)
      w1_flat[k*WIDTH +: WIDTH] = bank[OFF_W1 + k];
    for (int unsigned k = 0; k < OUTPUT_SIZE*HIDDEN_SIZE; k++)
      w2_flat[k*WIDTH +: WIDTH] = bank[OFF_W2 + k];
    for (int unsigned k = 0; k < HIDDEN_SIZE; k++)
      b1_flat[k*WIDTH +: WIDTH] = bank[OFF_B1 + k];
    for (int unsigned k = 0; k < OUTPUT_SIZE; k++)
      b2_flat[k*WIDTH +: WIDTH] = bank[OFF_B2 + k];
  end

endmodule

// File: tb/tb_nn_param_loader.sv
// Self-checking bench for nn_param_loader: scoreboard of written words plus a
// table of named bus slots, and hand-written short/long/reset/restart frames.
module tb_nn_param_loader;
  localparam int I = 10, H = 10, O = 5, W = 16;
  localparam int TOTAL = I + H*I + O*H + H + O;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0;
  logic [W-1:0] s_data = '0;
  logic s_ready, params_valid, load_done, frame_err;
  logic [I*W-1:0]   inputs_flat;
  logic [H*I*W-1:0] w1_flat;
  logic [O*H*W-1:0] w2_flat;
  logic [H*W-1:0]   b1_flat;
  logic [O*W-1:0]   b2_flat;

  nn_param_loader #(.INPUT_SIZE(I), .HIDDEN_SIZE(H), .OUTPUT_SIZE(O), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .inputs_flat(inputs_flat), .w1_flat(w1_flat),
    .w2_flat(w2_flat), .b1_flat(b1_flat), .b2_flat(b2_flat),
    .params_valid(params_valid), .load_done(load_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0;
  int ld_total = 0;
  always @(posedge clk) if (load_done === 1'b1) ld_total <= ld_total + 1;

  typedef struct { int idx; logic [W-1:0] d; } sb_t;
  sb_t sb_q[$];

  typedef struct { string name; int bus; int a; int b; logic [W-1:0] exp; } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream index -> bus slot, following the frame order.
  function automatic logic [W-1:0] slot(input int idx);
    logic [TOTAL*W-1:0] all;
    all = {b2_flat, b1_flat, w2_flat, w1_flat, inputs_flat};
    return all[idx*W +: W];
  endfunction

  function automatic logic [W-1:0] bus_elem(input int bus, input int a, input int b);
    case (bus)
      0: return inputs_flat[a*W +: W];
      1: return w1_flat[(a*I+b)*W +: W];
      2: return w2_flat[(a*H+b)*W +: W];
      3: return b1_flat[a*W +: W];
      default: return b2_flat[a*W +: W];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    int t = 0;
    while (s_ready !== 1'b1 && t < 50) begin tick(); t++; end
    if (s_ready !== 1'b1) begin
      n_vec++; n_miss++;
      $display("FAIL send_timeout: s_ready got %b required 1", s_ready);
    end
    s_valid = 1'b1; s_data = d; s_last = last;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic frame(input int nwords, input int last_idx, input logic [W-1:0] base,
                       input bit all_ones, input bit bubbles, input int start_at);
    logic [W-1:0] d;
    for (int n = 0; n < nwords; n++) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) tick();
        chk("bubble_cnt", 32'(dut.cnt), n);
        chk("bubble_ready", s_ready, 1);
      end
      d = all_ones ? 16'hFFFF : base + 16'(n);
      if (n < TOTAL) sb_q.push_back('{n, d});
      if (n == start_at) start = 1'b1;
      send(d, n == last_idx);
      start = 1'b0;
      if (n == start_at) begin
        chk("start_ignored_cnt", 32'(dut.cnt), n + 1);
        chk("start_ignored_ready", s_ready, 1);
      end
    end
  endtask

  task automatic drain_sb();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("slot%0d", e.idx), slot(e.idx), e.d);
    end
  endtask

  task automatic good_end_checks(input string tag);
    int ld0;
    ld0 = ld_total;
    chk({tag, "_ld_hi"}, load_done, 1);
    chk({tag, "_pv"}, params_valid, 1);
    chk({tag, "_fe"}, frame_err, 0);
    chk({tag, "_ready_lo"}, s_ready, 0);
    tick(); tick();
    chk({tag, "_ld_lo"}, load_done, 0);
    chk({tag, "_ld_once"}, ld_total - ld0, 1);
    chk({tag, "_pv_hold"}, params_valid, 1);
  endtask

  initial begin
    int ld0;
    vecs[0] = '{"in0",     0, 0, 0, 16'd1};
    vecs[1] = '{"w1_0_0",  1, 0, 0, 16'd11};
    vecs[2] = '{"w1_9_9",  1, 9, 9, 16'd110};
    vecs[3] = '{"w2_0_0",  2, 0, 0, 16'd111};
    vecs[4] = '{"w2_4_9",  2, 4, 9, 16'd160};
    vecs[5] = '{"b1_0",    3, 0, 0, 16'd161};
    vecs[6] = '{"b2_4",    4, 4, 0, 16'd175};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_pv", params_valid, 0);
    chk("rst_ld", load_done, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_buses", |{inputs_flat, w1_flat, w2_flat, b1_flat, b2_flat}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("idle_ready", s_ready, 0);

    // Full frame, no bubbles
    do_start();
    chk("start_ready", s_ready, 1);
    frame(TOTAL, TOTAL-1, 16'd1, 1'b0, 1'b0, -1);
    for (int k = 0; k < 7; k++)
      chk(vecs[k].name, bus_elem(vecs[k].bus, vecs[k].a, vecs[k].b), vecs[k].exp);
    drain_sb();
    good_end_checks("full");

    // Same data with random bubbles
    do_start();
    chk("restart_pv_clr", params_valid, 0);
    frame(TOTAL, TOTAL-1, 16'd1, 1'b0, 1'b1, -1);
    for (int k = 0; k < 7; k++)
      chk({vecs[k].name, "_bub"}, bus_elem(vecs[k].bus, vecs[k].a, vecs[k].b), vecs[k].exp);
    drain_sb();
    good_end_checks("bubble");

    // Short frame: s_last on word 99
    do_start();
    ld0 = ld_total;
    frame(100, 99, 16'd1000, 1'b0, 1'b0, -1);
    drain_sb();
    chk("short_ready", s_ready, 0);
    chk("short_fe", frame_err, 1);
    chk("short_pv", params_valid, 0);
    tick();
    chk("short_no_ld", ld_total - ld0, 0);
    do_start();
    chk("start_clr_fe", frame_err, 0);

    // Long frame: s_last on word 179, words 175..179 discarded
    ld0 = ld_total;
    frame(TOTAL + 5, TOTAL + 4, 16'd2000, 1'b0, 1'b0, -1);
    drain_sb();
    chk("long_ready", s_ready, 0);
    chk("long_fe", frame_err, 1);
    chk("long_pv", params_valid, 0);
    chk("long_slot174", slot(TOTAL-1), 16'd2000 + 16'(TOTAL-1));
    tick();
    chk("long_no_ld", ld_total - ld0, 0);

    // start pulsed mid-LOAD at word 50 is ignored
    do_start();
    frame(TOTAL, TOTAL-1, 16'd1, 1'b0, 1'b0, 50);
    drain_sb();
    good_end_checks("midstart");

    // rst_n dropped at word 80
    do_start();
    frame(80, -1, 16'd3000, 1'b0, 1'b0, -1);
    sb_q.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", s_ready, 0);
    chk("midrst_pv", params_valid, 0);
    chk("midrst_fe", frame_err, 0);
    chk("midrst_buses", |{inputs_flat, w1_flat, w2_flat, b1_flat, b2_flat}, 0);
    chk("midrst_cnt", 32'(dut.cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Good frame from index 0, then an all-ones frame
    do_start();
    frame(TOTAL, TOTAL-1, 16'd1, 1'b0, 1'b0, -1);
    drain_sb();
    good_end_checks("post_rst");
    do_start();
    chk("second_pv_drop", params_valid, 0);
    frame(TOTAL, TOTAL-1, 16'd0, 1'b1, 1'b0, -1);
    drain_sb();
    good_end_checks("ffff");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
